// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum display multiplexer.
//   state_t        : conversion FSM states
//   digit_t        : one 4-bit display digit
//   SEG_BLANK/DASH : fixed segment patterns {g,f,e,d,c,b,a}
//   dabble_adjust  : add-3 correction applied to every BCD nibble >= 5
package sum_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // A 13-bit sum (W=12 max) fits in 4 decimal digits or 4 hex digits.
  localparam int unsigned CONV_DIGITS = 4;
  localparam int unsigned BCD_W       = 4 * CONV_DIGITS;
  localparam int unsigned MAX_DIGITS  = 8;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(CONV_DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex digit to seven-segment decoder.
//   digit_i : 4-bit digit value 0..F
//   seg_o   : segments {g,f,e,d,c,b,a}, 1 = lit
module seven_seg_decoder
  import sum_display_pkg::*;
(
  input  digit_t     digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'h0: seg_o = 7'b0111111;
      4'h1: seg_o = 7'b0000110;
      4'h2: seg_o = 7'b1011011;
      4'h3: seg_o = 7'b1001111;
      4'h4: seg_o = 7'b1100110;
      4'h5: seg_o = 7'b1101101;
      4'h6: seg_o = 7'b1111101;
      4'h7: seg_o = 7'b0000111;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1101111;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b1111100;
      4'hC: seg_o = 7'b0111001;
      4'hD: seg_o = 7'b1011110;
      4'hE: seg_o = 7'b1111001;
      4'hF: seg_o = 7'b1110001;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_display_mux.sv
// Adds two button-entered operands and shows the sum, decimal or hex, on a
// time-multiplexed seven-segment display.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   btn_n    : active-low buttons, A = ~btn_n[W-1:0], B = ~btn_n[2W-1:W]
//   mode     : 0 = decimal, 1 = hexadecimal
//   seg      : segment drive {g,f,e,d,c,b,a}, 1 = lit
//   an       : one-hot digit enable, bit 0 = least significant digit
//   busy     : conversion in progress
//   overflow : sum does not fit in DIGITS digits of the current radix
module sum_display_mux
  import sum_display_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned LZB      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*W-1:0]    btn_n,
  input  logic              mode,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned SUM_W = W + 1;
  localparam int unsigned KEY_W = 2 * W + 1;
  localparam int unsigned SR_W  = BCD_W + SUM_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SEL_W = $clog2(MAX_DIGITS);

  logic [2*W-1:0] btn_s1_q, btn_s2_q;
  logic           mode_s1_q, mode_s2_q;

  logic [W-1:0]     a_s, b_s;
  logic [SUM_W-1:0] sum;
  logic [KEY_W-1:0] key;

  state_t                      state_q, state_d;
  logic [KEY_W-1:0]            last_q, last_d;
  logic [SR_W-1:0]             sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  digit_t [MAX_DIGITS-1:0]     disp_q, disp_d;
  logic                        ovf_q, ovf_d;
  logic                        busy_q, busy_d;
  logic [BCD_W-1:0]            conv_word;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  sel;
  logic [MAX_DIGITS-1:0] blank_vec;
  logic              above_zero;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  // Two-flop synchronizer; released buttons read as all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q  <= '1;
      btn_s2_q  <= '1;
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
    end else begin
      btn_s1_q  <= btn_n;
      btn_s2_q  <= btn_s1_q;
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
    end
  end

  assign a_s = ~btn_s2_q[W-1:0];
  assign b_s = ~btn_s2_q[2*W-1:W];
  assign sum = SUM_W'(a_s) + SUM_W'(b_s);
  assign key = {mode_s2_q, a_s, b_s};

  // Converted digits: BCD from the top of the shift register, hex straight from the sum.
  always_comb begin
    if (last_q[KEY_W-1]) begin
      conv_word = BCD_W'(sr_q[SUM_W-1:0]);
    end else begin
      conv_word = sr_q[SR_W-1 -: BCD_W];
    end
  end

  // Conversion FSM: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    sr_adj  = {dabble_adjust(sr_q[SR_W-1 -: BCD_W]), sr_q[SUM_W-1:0]};

    case (state_q)
      IDLE: begin
        if (key != last_q) begin
          last_d  = key;
          sr_d    = SR_W'(sum);
          cnt_d   = '0;
          state_d = mode_s2_q ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // All digits land together; any nonzero digit beyond DIGITS means overflow.
        disp_d = '0;
        ovf_d  = 1'b0;
        for (int i = 0; i < int'(CONV_DIGITS); i++) begin
          if (i < int'(DIGITS)) begin
            disp_d[i] = conv_word[4*i +: 4];
          end else if (conv_word[4*i +: 4] != 4'd0) begin
            ovf_d = 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Scan prescaler, digit select, blanking and output decode.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    sel = SEL_W'(idx_q);

    // A digit is blanked when it and every digit above it are zero.
    above_zero = 1'b1;
    blank_vec  = '0;
    for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
      above_zero   = above_zero && (disp_q[i] == 4'd0);
      blank_vec[i] = above_zero && (i != 0) && (LZB != 0);
    end

    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_vec[sel]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg;
    end
    an_d = DIGITS'(1) << idx_q;
  end

  seven_seg_decoder u_dec (
    .digit_i (disp_q[sel]),
    .seg_o   (dec_seg)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: doc/sum_display_mux.md
SUM_DISPLAY_MUX -- requirements
Module: sum_display_mux

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits (legal 1..12).
REQ-002 SHALL have parameter DIGITS, default 4, number of display digits (legal 1..8).
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit scan slot (legal >= 2).
REQ-004 SHALL have parameter LZB, default 1, leading-zero blanking enable.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port btn_n  input  2*W  raw active-low buttons; operand A = ~btn_n[W-1:0], operand B = ~btn_n[2W-1:W].
REQ-008 SHALL have port mode  input  1  0 = decimal sum, 1 = hexadecimal sum.
REQ-009 SHALL have port seg  output  7  segment drive {g,f,e,d,c,b,a}, 1 = lit.
REQ-010 SHALL have port an  output  DIGITS  one-hot digit enable, active-high, bit 0 = least significant digit.
REQ-011 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-012 SHALL have port overflow  output  1  sum not representable in DIGITS digits in the current mode.

Function
REQ-013 SHALL pass btn_n and mode through a two-flop synchronizer; all further logic uses the synchronized values.
REQ-014 SHALL compute sum = A + B at width W+1, with no truncation.
REQ-015 SHALL use FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL, in IDLE, start a conversion when the synchronized {mode, A, B} differs from the last-converted register.
- On start: latch {mode, A, B} into last-converted.
- Load sum into the shift register.
- Go to SHIFT if mode=0, else to DONE.
REQ-017 SHALL, in SHIFT, perform one double-dabble step per cycle: add 3 to each BCD nibble >= 5, then shift left 1; exactly W+1 SHIFT cycles, then go to DONE.
REQ-018 SHALL, in DONE, write all display digits atomically to the display register in one cycle, then go to IDLE.
REQ-019 SHALL make decimal latency from detection to display-register update W+3 cycles; hex latency SHALL be 2 cycles.
REQ-020 SHALL hold busy=1 in SHIFT and DONE and busy=0 in IDLE.
REQ-021 SHALL ignore input changes while busy; a change that persists is detected on return to IDLE.
REQ-022 SHALL, when the sum exceeds 10^DIGITS-1 (decimal) or 16^DIGITS-1 (hex), set overflow=1 and make every digit show a dash (g only, 7'b1000000); otherwise overflow=0.
- overflow updates in DONE.
REQ-023 SHALL, with LZB=1, blank every digit above the most significant nonzero digit (seg=0); digit 0 SHALL always show.
REQ-024 SHALL run a prescaler 0..SCAN_DIV-1.
- On wrap, advance the digit index 0..DIGITS-1, wrapping to 0.
REQ-025 SHALL register seg and an: an = one-hot(index) and seg = decode(display[index]), 1-cycle latency from index change.
REQ-026 SHALL decode hex digits 0-F, with values A-F as the standard segment patterns A, b, C, d, E, F.

Reset
REQ-027 SHALL, while rst=1, force FSM to IDLE and clear to 0: last-converted, display register, digit index, prescaler, seg, an, busy, overflow.
REQ-028 SHALL make an=1 and seg=7'b0111111 ("0") on the first clock after rst falls.
REQ-029 SHALL, on reset during SHIFT or DONE, abandon the conversion with no partial display update.

Structure
REQ-030 SHALL place in package sum_display_pkg:
- the FSM state enum;
- SEG_BLANK = 7'b0000000 and SEG_DASH = 7'b1000000;
- the 4-bit digit typedef.
REQ-031 SHALL implement segment decoding in sub-module seven_seg_decoder (4-bit in, 7-bit out, combinational), instantiated once on the selected digit.

Verification (W=4, DIGITS=4, SCAN_DIV=4, LZB=1)
REQ-032 SHALL check: rst pulse -> an=0001 and seg=7'b0111111 on the next cycle; an rotates 0001->0010->0100->1000->0001 every 4 cycles.
REQ-033 SHALL check: btn_n=8'b1000_0110 (A=9, B=7), mode=0 -> busy high 6 cycles; display reads 6,1,blank,blank; seg for digit 1 = 7'b0000110.
REQ-034 SHALL check: A=15, B=15, mode 0 -> display 0,3; toggle mode to 1 -> display E,1 within 2+2 cycles of synchronized change; overflow=0.
REQ-035 SHALL check: DIGITS=1, A=5, B=5, mode 0 -> overflow=1 and seg=7'b1000000; then B=4 -> overflow=0 and seg shows "9".
REQ-036 SHALL check: change A from 9 to 3 during SHIFT -> first display shows old sum, then one re-conversion shows new sum.
REQ-037 SHALL check: assert rst mid-SHIFT -> busy=0, display all "0"/blanked, overflow=0, with no stale digit displayed.
